// File: rtl/ex_alu_core_pkg.sv
// Shared widths, opcodes, condition codes and flag layout for the amber EX stage.
package ex_alu_core_pkg;

  localparam int HBIT_DATA   = 23;
  localparam int HBIT_ADDR   = 47;
  localparam int HBIT_OPC    = 7;
  localparam int HBIT_CC     = 3;
  localparam int HBIT_TGT_GP = 3;
  localparam int HBIT_TGT_AR = 1;
  localparam int HBIT_TGT_SR = 1;
  localparam int HBIT_SRC_GP = 3;
  localparam int HBIT_SRC_AR = 1;
  localparam int HBIT_SRC_SR = 1;
  localparam int HBIT_IMM14  = 13;
  localparam int HBIT_IMM12  = 11;
  localparam int HBIT_IMM10  = 9;
  localparam int HBIT_IMM16  = 15;
  localparam int HBIT_FLAGS  = 3;

  localparam logic [HBIT_OPC:0] OPC_ADDsr = 8'h10;
  localparam logic [HBIT_OPC:0] OPC_ADDsi = 8'h11;
  localparam logic [HBIT_OPC:0] OPC_SUBsr = 8'h12;
  localparam logic [HBIT_OPC:0] OPC_SUBsi = 8'h13;
  localparam logic [HBIT_OPC:0] OPC_NEGsr = 8'h14;
  localparam logic [HBIT_OPC:0] OPC_SHRsr = 8'h15;
  localparam logic [HBIT_OPC:0] OPC_SHRsi = 8'h16;
  localparam logic [HBIT_OPC:0] OPC_CMPsr = 8'h17;
  localparam logic [HBIT_OPC:0] OPC_CMPsi = 8'h18;
  localparam logic [HBIT_OPC:0] OPC_TSTsr = 8'h19;
  localparam logic [HBIT_OPC:0] OPC_MOVsi = 8'h1A;
  localparam logic [HBIT_OPC:0] OPC_MCCsi = 8'h1B;

  typedef enum logic [HBIT_CC:0] {
    CC_AL = 4'd0,
    CC_EQ = 4'd1,
    CC_NE = 4'd2,
    CC_LT = 4'd3,
    CC_GE = 4'd4,
    CC_GT = 4'd5,
    CC_LE = 4'd6,
    CC_BT = 4'd7,
    CC_AE = 4'd8
  } cc_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [HBIT_TGT_SR:0] SR_FL = 2'd2;

  function automatic logic [HBIT_DATA:0] sext12(input logic [HBIT_IMM12:0] v);
    return {{(HBIT_DATA - HBIT_IMM12){v[HBIT_IMM12]}}, v};
  endfunction

endpackage

// File: rtl/ex_alu_core_cc_eval.sv
// Condition-code evaluator: decides whether a conditional op fires on Z/N/C/V.
module ex_cc_eval
  import ex_alu_core_pkg::*;
(
  input  logic [HBIT_CC:0]    cc_i,
  input  logic [HBIT_FLAGS:0] flags_i,
  output logic                taken_o
);

  logic z, n, c, v, lt;

  assign z  = flags_i[FLAG_Z];
  assign n  = flags_i[FLAG_N];
  assign c  = flags_i[FLAG_C];
  assign v  = flags_i[FLAG_V];
  assign lt = n ^ v;

  always_comb begin
    taken_o = 1'b0;
    case (cc_i)
      CC_AL:   taken_o = 1'b1;
      CC_EQ:   taken_o = z;
      CC_NE:   taken_o = ~z;
      CC_LT:   taken_o = lt;
      CC_GE:   taken_o = ~lt;
      CC_GT:   taken_o = ~z & ~lt;
      CC_LE:   taken_o = z | lt;
      CC_BT:   taken_o = c;
      CC_AE:   taken_o = ~c;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_alu_core.sv
// Amber EX stage for the signed ALU group: computes GP and flag results and
// registers them with the pass-through control into the EX/MEM register.
module ex_alu_core
  import ex_alu_core_pkg::*;
(
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [HBIT_ADDR:0]     iw_pc,
  output logic [HBIT_ADDR:0]     ow_pc,
  input  logic [HBIT_DATA:0]     iw_instr,
  output logic [HBIT_DATA:0]     ow_instr,
  input  logic [HBIT_OPC:0]      iw_opc,
  output logic [HBIT_OPC:0]      ow_opc,
  input  logic                   iw_sgn_en,
  input  logic                   iw_imm_en,
  input  logic [HBIT_IMM14:0]    iw_imm14_val,
  input  logic [HBIT_IMM12:0]    iw_imm12_val,
  input  logic [HBIT_IMM10:0]    iw_imm10_val,
  input  logic [HBIT_IMM16:0]    iw_imm16_val,
  input  logic [HBIT_CC:0]       iw_cc,
  input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  output logic [HBIT_TGT_GP:0]   ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  output logic [HBIT_TGT_SR:0]   ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  input  logic [HBIT_TGT_AR:0]   iw_tgt_ar,
  output logic [HBIT_TGT_AR:0]   ow_tgt_ar,
  output logic                   ow_tgt_ar_we,
  input  logic [HBIT_SRC_GP:0]   iw_src_gp,
  input  logic [HBIT_SRC_AR:0]   iw_src_ar,
  input  logic [HBIT_SRC_SR:0]   iw_src_sr,
  input  logic [HBIT_DATA:0]     iw_src_gp_val,
  input  logic [HBIT_DATA:0]     iw_tgt_gp_val,
  input  logic [HBIT_ADDR:0]     iw_src_ar_val,
  input  logic [HBIT_ADDR:0]     iw_tgt_ar_val,
  input  logic [HBIT_ADDR:0]     iw_src_sr_val,
  input  logic [HBIT_ADDR:0]     iw_tgt_sr_val,
  output logic [HBIT_ADDR:0]     ow_addr,
  output logic [HBIT_DATA:0]     ow_result,
  output logic [HBIT_ADDR:0]     ow_ar_result,
  output logic [HBIT_ADDR:0]     ow_sr_result,
  output logic                   ow_branch_taken,
  output logic [HBIT_ADDR:0]     ow_branch_pc,
  input  logic                   iw_flush,
  input  logic                   iw_stall
);

  logic [HBIT_DATA:0]   t_val, imm_sx, mcc_sx, opb;
  logic                 is_si, is_neg;
  logic [HBIT_DATA+1:0] add_sum, sub_diff;
  logic [HBIT_DATA:0]   sub_a, sub_b;
  logic                 add_v, sub_v;
  logic [4:0]           shr_amt;
  logic signed [HBIT_DATA+1:0] shr_ext;
  logic                 cc_taken;

  logic [HBIT_DATA:0]   alu_res;
  logic                 fl_c, fl_v, set_fl, wr_gp, known;
  logic [HBIT_FLAGS:0]  flags_new;

  logic [HBIT_ADDR:0]   pc_q, pc_d, sr_result_q, sr_result_d;
  logic [HBIT_DATA:0]   instr_q, instr_d, result_q, result_d;
  logic [HBIT_OPC:0]    opc_q, opc_d;
  logic [HBIT_TGT_GP:0] tgt_gp_q, tgt_gp_d;
  logic [HBIT_TGT_SR:0] tgt_sr_q, tgt_sr_d;
  logic [HBIT_TGT_AR:0] tgt_ar_q, tgt_ar_d;
  logic                 tgt_gp_we_q, tgt_gp_we_d, tgt_sr_we_q, tgt_sr_we_d;

  logic unused_inputs;
  assign unused_inputs = ^{iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm10_val,
                           iw_imm16_val, iw_src_gp, iw_src_ar, iw_src_sr,
                           iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val[HBIT_ADDR:4]};

  assign t_val  = iw_tgt_gp_val;
  assign imm_sx = sext12(iw_imm12_val);
  assign mcc_sx = {{(HBIT_DATA - 7){iw_instr[7]}}, iw_instr[7:0]};
  assign is_si  = (iw_opc == OPC_ADDsi) || (iw_opc == OPC_SUBsi) ||
                  (iw_opc == OPC_SHRsi) || (iw_opc == OPC_CMPsi);
  assign is_neg = (iw_opc == OPC_NEGsr);
  assign opb    = is_si ? imm_sx : iw_src_gp_val;

  // NEG reuses the subtractor as 0 - T; bit 24 of the difference is the borrow.
  assign sub_a    = is_neg ? '0 : t_val;
  assign sub_b    = is_neg ? t_val : opb;
  assign add_sum  = {1'b0, t_val} + {1'b0, opb};
  assign sub_diff = {1'b0, sub_a} - {1'b0, sub_b};
  assign add_v    = (t_val[HBIT_DATA] == opb[HBIT_DATA]) &&
                    (add_sum[HBIT_DATA] != t_val[HBIT_DATA]);
  assign sub_v    = (sub_a[HBIT_DATA] != sub_b[HBIT_DATA]) &&
                    (sub_diff[HBIT_DATA] != sub_a[HBIT_DATA]);

  // Shifting {T,0} leaves the last bit shifted out in bit 0; amounts >= 24 saturate to sign.
  assign shr_amt = opb[4:0];
  assign shr_ext = $signed({t_val, 1'b0}) >>> shr_amt;

  ex_cc_eval u_cc_eval (
    .cc_i    (iw_cc),
    .flags_i (iw_src_sr_val[HBIT_FLAGS:0]),
    .taken_o (cc_taken)
  );

  always_comb begin
    alu_res = '0;
    fl_c    = 1'b0;
    fl_v    = 1'b0;
    set_fl  = 1'b0;
    wr_gp   = 1'b0;
    known   = 1'b0;
    case (iw_opc)
      OPC_ADDsr, OPC_ADDsi: begin
        alu_res = add_sum[HBIT_DATA:0];
        fl_c    = add_sum[HBIT_DATA+1];
        fl_v    = add_v;
        set_fl  = 1'b1;
        wr_gp   = 1'b1;
        known   = 1'b1;
      end
      OPC_SUBsr, OPC_SUBsi, OPC_NEGsr, OPC_CMPsr, OPC_CMPsi: begin
        alu_res = sub_diff[HBIT_DATA:0];
        fl_c    = sub_diff[HBIT_DATA+1];
        fl_v    = sub_v;
        set_fl  = 1'b1;
        wr_gp   = (iw_opc != OPC_CMPsr) && (iw_opc != OPC_CMPsi);
        known   = 1'b1;
      end
      OPC_SHRsr, OPC_SHRsi: begin
        alu_res = shr_ext[HBIT_DATA+1:1];
        fl_c    = shr_ext[0];
        set_fl  = 1'b1;
        wr_gp   = 1'b1;
        known   = 1'b1;
      end
      OPC_TSTsr: begin
        alu_res = t_val;
        set_fl  = 1'b1;
        known   = 1'b1;
      end
      OPC_MOVsi: begin
        alu_res = imm_sx;
        wr_gp   = 1'b1;
        known   = 1'b1;
      end
      OPC_MCCsi: begin
        alu_res = mcc_sx;
        wr_gp   = cc_taken;
        known   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    flags_new         = '0;
    flags_new[FLAG_Z] = ~|alu_res;
    flags_new[FLAG_N] = alu_res[HBIT_DATA];
    flags_new[FLAG_C] = fl_c;
    flags_new[FLAG_V] = fl_v;

    pc_d        = iw_pc;
    instr_d     = iw_instr;
    opc_d       = iw_opc;
    tgt_gp_d    = iw_tgt_gp;
    tgt_ar_d    = iw_tgt_ar;
    result_d    = alu_res;
    tgt_gp_we_d = iw_tgt_gp_we & wr_gp;
    tgt_sr_d    = set_fl ? SR_FL : iw_tgt_sr;
    tgt_sr_we_d = set_fl | (known & iw_tgt_sr_we);
    sr_result_d = set_fl ? {iw_tgt_sr_val[HBIT_ADDR:HBIT_FLAGS+1], flags_new}
                         : iw_tgt_sr_val;
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst || iw_flush) begin
      pc_q        <= '0;
      instr_q     <= '0;
      opc_q       <= '0;
      tgt_gp_q    <= '0;
      tgt_ar_q    <= '0;
      tgt_sr_q    <= '0;
      result_q    <= '0;
      sr_result_q <= '0;
      tgt_gp_we_q <= 1'b0;
      tgt_sr_we_q <= 1'b0;
    end else if (!iw_stall) begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      opc_q       <= opc_d;
      tgt_gp_q    <= tgt_gp_d;
      tgt_ar_q    <= tgt_ar_d;
      tgt_sr_q    <= tgt_sr_d;
      result_q    <= result_d;
      sr_result_q <= sr_result_d;
      tgt_gp_we_q <= tgt_gp_we_d;
      tgt_sr_we_q <= tgt_sr_we_d;
    end
  end

  assign ow_pc           = pc_q;
  assign ow_instr        = instr_q;
  assign ow_opc          = opc_q;
  assign ow_tgt_gp       = tgt_gp_q;
  assign ow_tgt_gp_we    = tgt_gp_we_q;
  assign ow_tgt_sr       = tgt_sr_q;
  assign ow_tgt_sr_we    = tgt_sr_we_q;
  assign ow_tgt_ar       = tgt_ar_q;
  assign ow_result       = result_q;
  assign ow_sr_result    = sr_result_q;
  // AR writes and branches belong to other execute groups.
  assign ow_tgt_ar_we    = 1'b0;
  assign ow_ar_result    = '0;
  assign ow_addr         = '0;
  assign ow_branch_taken = 1'b0;
  assign ow_branch_pc    = '0;

endmodule

// File: tb/tb_ex_alu_core.sv
// Self-checking bench for ex_alu_core: directed table, random vs. arithmetic model, control corners.
module tb_ex_alu_core;
  import ex_alu_core_pkg::*;

  logic        iw_clk = 1'b0;
  logic        iw_rst;
  logic [47:0] iw_pc, ow_pc;
  logic [23:0] iw_instr, ow_instr;
  logic [7:0]  iw_opc, ow_opc;
  logic        iw_sgn_en, iw_imm_en;
  logic [13:0] iw_imm14_val;
  logic [11:0] iw_imm12_val;
  logic [9:0]  iw_imm10_val;
  logic [15:0] iw_imm16_val;
  logic [3:0]  iw_cc;
  logic [3:0]  iw_tgt_gp, ow_tgt_gp;
  logic        iw_tgt_gp_we, ow_tgt_gp_we;
  logic [1:0]  iw_tgt_sr, ow_tgt_sr;
  logic        iw_tgt_sr_we, ow_tgt_sr_we;
  logic [1:0]  iw_tgt_ar, ow_tgt_ar;
  logic        ow_tgt_ar_we;
  logic [3:0]  iw_src_gp;
  logic [1:0]  iw_src_ar, iw_src_sr;
  logic [23:0] iw_src_gp_val, iw_tgt_gp_val;
  logic [47:0] iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val;
  logic [47:0] ow_addr, ow_ar_result, ow_sr_result, ow_branch_pc;
  logic [23:0] ow_result;
  logic        ow_branch_taken;
  logic        iw_flush, iw_stall;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [47:0] SRV = 48'h123456_789AB0;

  ex_alu_core dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .ow_pc(ow_pc),
    .iw_instr(iw_instr), .ow_instr(ow_instr), .iw_opc(iw_opc), .ow_opc(ow_opc),
    .iw_sgn_en(iw_sgn_en), .iw_imm_en(iw_imm_en), .iw_imm14_val(iw_imm14_val),
    .iw_imm12_val(iw_imm12_val), .iw_imm10_val(iw_imm10_val), .iw_imm16_val(iw_imm16_val),
    .iw_cc(iw_cc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we), .iw_tgt_sr(iw_tgt_sr),
    .iw_tgt_sr_we(iw_tgt_sr_we), .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
    .iw_tgt_ar(iw_tgt_ar), .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
    .iw_src_gp(iw_src_gp), .iw_src_ar(iw_src_ar), .iw_src_sr(iw_src_sr),
    .iw_src_gp_val(iw_src_gp_val), .iw_tgt_gp_val(iw_tgt_gp_val),
    .iw_src_ar_val(iw_src_ar_val), .iw_tgt_ar_val(iw_tgt_ar_val),
    .iw_src_sr_val(iw_src_sr_val), .iw_tgt_sr_val(iw_tgt_sr_val),
    .ow_addr(ow_addr), .ow_result(ow_result), .ow_ar_result(ow_ar_result),
    .ow_sr_result(ow_sr_result), .ow_branch_taken(ow_branch_taken),
    .ow_branch_pc(ow_branch_pc), .iw_flush(iw_flush), .iw_stall(iw_stall)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    string       name;
    logic [7:0]  opc;
    logic [23:0] t, s;
    logic [11:0] imm;
    logic [7:0]  i8;
    logic [3:0]  cc, fl_in;
    logic        sr_we_in;
    logic        chk_res;
    logic [23:0] exp_res;
    logic        exp_gp_we, exp_sr_we, sets_fl;
    logic [3:0]  exp_fl;   // {V,C,N,Z}
  } vec_t;

  typedef struct {
    logic        known, sets_fl, gp_op;
    logic [23:0] res;
    logic        gp_we, sr_we;
    logic [47:0] sr_res;
  } exp_t;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic defaults();
    iw_pc = 48'h0; iw_instr = 24'h0; iw_opc = 8'h00; iw_sgn_en = 1'b0; iw_imm_en = 1'b0;
    iw_imm14_val = '0; iw_imm12_val = '0; iw_imm10_val = '0; iw_imm16_val = '0;
    iw_cc = 4'd0; iw_tgt_gp = 4'd5; iw_tgt_gp_we = 1'b1; iw_tgt_sr = 2'd1; iw_tgt_sr_we = 1'b0;
    iw_tgt_ar = 2'd3; iw_src_gp = 4'd2; iw_src_ar = 2'd1; iw_src_sr = 2'd2;
    iw_src_gp_val = '0; iw_tgt_gp_val = '0; iw_src_ar_val = '0; iw_tgt_ar_val = '0;
    iw_src_sr_val = '0; iw_tgt_sr_val = SRV; iw_flush = 1'b0; iw_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] opc, input logic [23:0] t, s, input logic [11:0] imm,
                       input logic [7:0] i8, input logic [3:0] cc, fl, input logic srwe,
                       input logic [47:0] pc);
    @(negedge iw_clk);
    iw_opc = opc; iw_tgt_gp_val = t; iw_src_gp_val = s; iw_imm12_val = imm;
    iw_instr = {16'hA5C3, i8}; iw_cc = cc; iw_src_sr_val = {44'hFEDCBA98765, fl};
    iw_tgt_sr_we = srwe; iw_pc = pc;
  endtask

  // Reference model: plain integer arithmetic on signed/unsigned interpretations.
  function automatic int sx24(input logic [23:0] x);
    return (x >= 24'h800000) ? int'(x) - 32'h0100_0000 : int'(x);
  endfunction

  function automatic bit cond(input logic [3:0] cc, input logic [3:0] f);
    bit z, n, c, v;
    z = f[0]; n = f[1]; c = f[2]; v = f[3];
    case (cc)
      4'd0: return 1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n != v;
      4'd4: return n == v;
      4'd5: return !z && (n == v);
      4'd6: return z || (n != v);
      4'd7: return c;
      4'd8: return !c;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] opc, input logic [23:0] t, s,
                                 input logic [11:0] imm, input logic [7:0] i8,
                                 input logic [3:0] cc, fl, input logic srwe);
    exp_t e;
    int ib, sv, a, bb, amt;
    longint unsigned u;
    logic [23:0] b, x, r;
    bit c, v, si;
    e = '{default: 0};
    ib = int'(imm); if (ib >= 2048) ib -= 4096;
    si = (opc == OPC_ADDsi) || (opc == OPC_SUBsi) || (opc == OPC_SHRsi) || (opc == OPC_CMPsi);
    b = si ? ib[23:0] : s;
    c = 0; v = 0; r = 0;
    case (opc)
      OPC_ADDsr, OPC_ADDsi: begin
        u = longint'(t) + longint'(b); r = u[23:0]; c = (u > 64'hFFFFFF);
        sv = sx24(t) + sx24(b); v = (sv > 8388607) || (sv < -8388608);
        e.known = 1; e.sets_fl = 1; e.gp_op = 1;
      end
      OPC_SUBsr, OPC_SUBsi, OPC_CMPsr, OPC_CMPsi, OPC_NEGsr: begin
        a  = (opc == OPC_NEGsr) ? 0 : int'(t);
        bb = (opc == OPC_NEGsr) ? int'(t) : int'(b);
        c  = (a < bb);
        r  = 24'(a - bb);
        sv = ((opc == OPC_NEGsr) ? 0 : sx24(t)) - sx24(24'(bb));
        v  = (sv > 8388607) || (sv < -8388608);
        e.known = 1; e.sets_fl = 1;
        e.gp_op = (opc != OPC_CMPsr) && (opc != OPC_CMPsi);
      end
      OPC_SHRsr, OPC_SHRsi: begin
        amt = int'(b[4:0]); x = t;
        for (int k = 0; k < amt; k++) begin
          c = x[0];
          x = {x[23], x[23:1]};
        end
        r = x; e.known = 1; e.sets_fl = 1; e.gp_op = 1;
      end
      OPC_TSTsr: begin r = t; e.known = 1; e.sets_fl = 1; end
      OPC_MOVsi: begin r = ib[23:0]; e.known = 1; e.gp_op = 1; end
      OPC_MCCsi: begin
        r = (i8 >= 8'h80) ? {16'hFFFF, i8} : {16'h0000, i8};
        e.known = 1; e.gp_op = cond(cc, fl);
      end
      default: ;
    endcase
    e.res   = r;
    e.gp_we = e.gp_op;
    e.sr_we = e.sets_fl || (e.known && srwe);
    e.sr_res = e.sets_fl ? {SRV[47:4], v, c, r[23], (r == 0)} : SRV;
    return e;
  endfunction

  function automatic vec_t mk(input string nm, input logic [7:0] opc, input logic [23:0] t, s,
                              input logic [11:0] imm, input logic [7:0] i8, input logic [3:0] cc,
                              fl, input logic srwe, chkr, input logic [23:0] er,
                              input logic egw, esw, sfl, input logic [3:0] efl);
    vec_t v;
    v.name = nm; v.opc = opc; v.t = t; v.s = s; v.imm = imm; v.i8 = i8; v.cc = cc;
    v.fl_in = fl; v.sr_we_in = srwe; v.chk_res = chkr; v.exp_res = er;
    v.exp_gp_we = egw; v.exp_sr_we = esw; v.sets_fl = sfl; v.exp_fl = efl;
    return v;
  endfunction

  vec_t vt[$];
  logic [7:0] opcs [13];

  initial begin
    exp_t e;
    logic [23:0] rt, rs;
    logic [47:0] pc;

    defaults();
    iw_rst = 1'b0;
    tick(); tick();
    chk("rst_result", {24'h0, ow_result}, 48'h0);
    chk("rst_sr_result", ow_sr_result, 48'h0);
    chk("rst_pc", ow_pc, 48'h0);
    chk("rst_we", {46'h0, ow_tgt_gp_we, ow_tgt_sr_we}, 48'h0);
    chk("rst_const", {45'h0, ow_branch_taken, ow_tgt_ar_we, |ow_addr}, 48'h0);
    @(negedge iw_clk);
    iw_rst = 1'b1;

    //        name      opc        T          S          imm     i8     cc  fl    srwe chk res        gpwe srwe setfl {V,C,N,Z}
    vt.push_back(mk("neg1",   OPC_NEGsr, 24'h000001, 24'h0,      12'h0,  8'h0,  4'd0, 4'h0, 0, 1, 24'hFFFFFF, 1, 1, 1, 4'b0110));
    vt.push_back(mk("add_ov", OPC_ADDsr, 24'h7FFFFF, 24'h1,      12'h0,  8'h0,  4'd0, 4'h0, 0, 1, 24'h800000, 1, 1, 1, 4'b1010));
    vt.push_back(mk("sub_ov", OPC_SUBsr, 24'h800000, 24'h1,      12'h0,  8'h0,  4'd0, 4'h0, 0, 1, 24'h7FFFFF, 1, 1, 1, 4'b1000));
    vt.push_back(mk("shr_r",  OPC_SHRsr, 24'h800002, 24'h1,      12'h0,  8'h0,  4'd0, 4'h0, 0, 1, 24'hC00001, 1, 1, 1, 4'b0010));
    vt.push_back(mk("shr_i",  OPC_SHRsi, 24'h800000, 24'h0,      12'h1,  8'h0,  4'd0, 4'h0, 0, 1, 24'hC00000, 1, 1, 1, 4'b0010));
    vt.push_back(mk("shr_30", OPC_SHRsr, 24'h800000, 24'h1E,     12'h0,  8'h0,  4'd0, 4'h0, 0, 1, 24'hFFFFFF, 1, 1, 1, 4'b0110));
    vt.push_back(mk("mov_i",  OPC_MOVsi, 24'h0,      24'h0,      12'hF80, 8'h0, 4'd0, 4'h0, 0, 1, 24'hFFFF80, 1, 0, 0, 4'b0000));
    vt.push_back(mk("mcc_t",  OPC_MCCsi, 24'h0,      24'h0,      12'h0,  8'h80, 4'd1, 4'h1, 1, 1, 24'hFFFF80, 1, 1, 0, 4'b0000));
    vt.push_back(mk("mcc_f",  OPC_MCCsi, 24'h0,      24'h0,      12'h0,  8'h80, 4'd1, 4'h0, 0, 1, 24'hFFFF80, 0, 0, 0, 4'b0000));
    vt.push_back(mk("add_i",  OPC_ADDsi, 24'h000010, 24'h0,      12'h2,  8'h0,  4'd0, 4'h0, 0, 1, 24'h000012, 1, 1, 1, 4'b0000));
    vt.push_back(mk("sub_i",  OPC_SUBsi, 24'h000010, 24'h0,      12'h4,  8'h0,  4'd0, 4'h0, 0, 1, 24'h00000C, 1, 1, 1, 4'b0000));
    vt.push_back(mk("cmp_i",  OPC_CMPsi, 24'h0,      24'h0,      12'h0,  8'h0,  4'd0, 4'h0, 0, 0, 24'h0,      0, 1, 1, 4'b0001));
    vt.push_back(mk("tst",    OPC_TSTsr, 24'h800000, 24'h0,      12'h0,  8'h0,  4'd0, 4'h0, 0, 0, 24'h0,      0, 1, 1, 4'b0010));
    vt.push_back(mk("nop",    8'hFF,     24'h123456, 24'h1,      12'h5,  8'h0,  4'd0, 4'h0, 1, 0, 24'h0,      0, 0, 0, 4'b0000));

    foreach (vt[i]) begin
      pc = 48'h1000 + 48'(i * 3);
      drive(vt[i].opc, vt[i].t, vt[i].s, vt[i].imm, vt[i].i8, vt[i].cc, vt[i].fl_in, vt[i].sr_we_in, pc);
      tick();
      $display("vec %s opc=%02h T=%06h -> res=%06h gp_we=%0b sr_we=%0b sr=%012h",
               vt[i].name, vt[i].opc, vt[i].t, ow_result, ow_tgt_gp_we, ow_tgt_sr_we, ow_sr_result);
      if (vt[i].chk_res) chk({vt[i].name, "_res"}, {24'h0, ow_result}, {24'h0, vt[i].exp_res});
      chk({vt[i].name, "_gp_we"}, {47'h0, ow_tgt_gp_we}, {47'h0, vt[i].exp_gp_we});
      chk({vt[i].name, "_sr_we"}, {47'h0, ow_tgt_sr_we}, {47'h0, vt[i].exp_sr_we});
      if (vt[i].sets_fl) begin
        chk({vt[i].name, "_sr_res"}, ow_sr_result, {SRV[47:4], vt[i].exp_fl});
        chk({vt[i].name, "_tgt_sr"}, {46'h0, ow_tgt_sr}, 48'd2);
      end
      chk({vt[i].name, "_pc"}, ow_pc, pc);
      chk({vt[i].name, "_opc"}, {40'h0, ow_opc}, {40'h0, vt[i].opc});
    end

    opcs = '{OPC_ADDsr, OPC_ADDsi, OPC_SUBsr, OPC_SUBsi, OPC_NEGsr, OPC_SHRsr, OPC_SHRsi,
             OPC_CMPsr, OPC_CMPsi, OPC_TSTsr, OPC_MOVsi, OPC_MCCsi, 8'h3C};
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  op;
      logic [11:0] im;
      logic [7:0]  i8;
      logic [3:0]  cc, fl;
      logic        sw;
      op = opcs[$urandom_range(0, 12)];
      case ($urandom_range(0, 5))
        0: rt = 24'h0; 1: rt = 24'h7FFFFF; 2: rt = 24'h800000; 3: rt = 24'hFFFFFF;
        default: rt = 24'($urandom);
      endcase
      rs = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 40)) : 24'($urandom);
      im = 12'($urandom); i8 = 8'($urandom); cc = 4'($urandom_range(0, 10));
      fl = 4'($urandom); sw = 1'($urandom);
      pc = {16'h0, 32'($urandom)};
      drive(op, rt, rs, im, i8, cc, fl, sw, pc);
      e = model(op, rt, rs, im, i8, cc, fl, sw);
      tick();
      $display("rnd %0d opc=%02h T=%06h S=%06h imm=%03h -> res=%06h gp_we=%0b sr_we=%0b",
               n, op, rt, rs, im, ow_result, ow_tgt_gp_we, ow_tgt_sr_we);
      chk("rnd_gp_we", {47'h0, ow_tgt_gp_we}, {47'h0, e.gp_we});
      chk("rnd_sr_we", {47'h0, ow_tgt_sr_we}, {47'h0, e.sr_we});
      if (e.known && (e.gp_op || op == OPC_MCCsi))
        chk("rnd_res", {24'h0, ow_result}, {24'h0, e.res});
      if (e.known) chk("rnd_sr_res", ow_sr_result, e.sr_res);
      chk("rnd_pc", ow_pc, pc);
    end

    // Stall holds the previous result even with new, different inputs.
    drive(OPC_ADDsi, 24'h10, 24'h0, 12'h2, 8'h0, 4'd0, 4'h0, 1'b0, 48'hAAAA);
    tick();
    drive(OPC_SUBsr, 24'h999, 24'h1, 12'h0, 8'h0, 4'd0, 4'h0, 1'b0, 48'hBBBB);
    iw_stall = 1'b1;
    tick();
    $display("stall res=%06h pc=%0h gp_we=%0b", ow_result, ow_pc, ow_tgt_gp_we);
    chk("stall_res", {24'h0, ow_result}, 48'h12);
    chk("stall_pc", ow_pc, 48'hAAAA);
    chk("stall_gp_we", {47'h0, ow_tgt_gp_we}, 48'h1);
    tick();
    chk("stall2_res", {24'h0, ow_result}, 48'h12);

    // Flush wins over stall and loads a bubble.
    @(negedge iw_clk);
    iw_flush = 1'b1;
    tick();
    $display("flush res=%06h gp_we=%0b sr_we=%0b", ow_result, ow_tgt_gp_we, ow_tgt_sr_we);
    chk("flush_we", {46'h0, ow_tgt_gp_we, ow_tgt_sr_we}, 48'h0);
    chk("flush_res", {24'h0, ow_result}, 48'h0);
    chk("flush_sr_res", ow_sr_result, 48'h0);
    chk("flush_br", {47'h0, ow_branch_taken}, 48'h0);

    // Reset mid-stream, with flush and stall deasserted and a valid op presented.
    @(negedge iw_clk);
    iw_flush = 1'b0; iw_stall = 1'b0;
    drive(OPC_NEGsr, 24'h1, 24'h0, 12'h0, 8'h0, 4'd0, 4'h0, 1'b0, 48'hCCCC);
    tick();
    chk("pre_rst_res", {24'h0, ow_result}, 48'hFFFFFF);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    tick();
    $display("reset res=%06h pc=%0h sr=%012h", ow_result, ow_pc, ow_sr_result);
    chk("mid_rst_res", {24'h0, ow_result}, 48'h0);
    chk("mid_rst_pc", ow_pc, 48'h0);
    chk("mid_rst_sr", ow_sr_result, 48'h0);
    chk("mid_rst_we", {46'h0, ow_tgt_gp_we, ow_tgt_sr_we}, 48'h0);
    @(negedge iw_clk);
    iw_rst = 1'b1;
    tick();
    chk("post_rst_res", {24'h0, ow_result}, 48'hFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
